// File: rtl/rw_seq_pkg.sv
// rtl/rw_seq_pkg.sv - shared types and constants for the ReWire step sequencer
// Purpose: FSM state encoding, default geometry and the step counter limits.
// Ports: none (package).
package rw_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int                      STEP_COUNT_W   = 16;
  localparam logic [STEP_COUNT_W-1:0] STEP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rw_seq_fifo.sv
// rtl/rw_seq_fifo.sv - synchronous FIFO holding Just outputs of the stepped device
// Purpose: DEPTH-entry FIFO (DEPTH a power of two) with registered head.
// Ports: clk, rst (async, active-high); push/push_data write side;
//        pop/pop_data read side (pop_data is the current head);
//        full, empty, count status.
module rw_seq_fifo
  import rw_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Storage is cleared on reset so the head reads zero after any reset.
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so natural overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rw_step_sequencer.sv
// rtl/rw_step_sequencer.sv - fires one ReWire device step per accepted input word
// Purpose: accept words on in_valid/in_ready, pulse dev_step for one cycle per word,
//          queue Just outputs, latch termination when the device drops continue.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data upstream;
//        dev_step/dev_in to device, dev_continue/dev_out_tag/dev_out_data from it;
//        out_valid/out_ready/out_data downstream; done (sticky), step_count (saturating).
module rw_step_sequencer
  import rw_seq_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    dev_step,
  output logic [DATA_W-1:0]       dev_in,
  input  logic                    dev_continue,
  input  logic                    dev_out_tag,
  input  logic [DATA_W-1:0]       dev_out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    done,
  output logic [STEP_COUNT_W-1:0] step_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_t              state;
  logic [DATA_W-1:0]       dev_in_q;
  logic [STEP_COUNT_W-1:0] step_count_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;

  // Only one step is ever outstanding, so a free slot at acceptance is the
  // reservation for that step's output. rst gates in_ready low while held.
  assign in_ready   = !rst && (state == IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign dev_step   = (state == STEP);
  assign done       = (state == HALTED);
  assign dev_in     = dev_in_q;
  assign step_count = step_count_q;

  assign fifo_push  = (state == STEP) && dev_out_tag && !fifo_full;
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;

  rw_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (dev_out_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dev_in_q     <= '0;
      step_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dev_in_q <= in_data;
            state    <= STEP;
          end
        end
        STEP: begin
          if (step_count_q != STEP_COUNT_MAX) begin
            step_count_q <= step_count_q + 1'b1;
          end
          state <= dev_continue ? IDLE : HALTED;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rw_step_sequencer.md
# rw_step_sequencer

Controller that sequences a compiled ReWire step device: an 8-bit-state machine whose ports are an input word, a continue flag, a Maybe-tagged output and a registered state. The sequencer accepts input words over a valid/ready handshake and fires exactly one device step per accepted word. It captures Just outputs into a small FIFO, discards Nothing outputs, and latches termination when the device drops continue. It sits between the system stream fabric and the device's clock-enable.

## Interface
Parameters:
- DATA_W, 8, width of device input and output payload
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  sequencer can accept a word
- in_data  in  DATA_W  upstream word
- dev_step  out  1  device clock-enable; the device commits its next state on the clk edge ending a cycle with dev_step=1
- dev_in  out  DATA_W  word presented to the device input
- dev_continue  in  1  device continue flag, combinational from dev_in and device state
- dev_out_tag  in  1  device Maybe tag (1=Just, 0=Nothing)
- dev_out_data  in  DATA_W  device Just payload
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  DATA_W  FIFO head
- done  out  1  sticky: device terminated
- step_count  out  16  steps fired since reset, saturating

## Operation
- States: IDLE, STEP, HALTED.
- IDLE: in_ready = (fifo_count < FIFO_DEPTH). On in_valid & in_ready, latch in_data into dev_in and go to STEP.
- STEP, one cycle, in this order:
  - Assert dev_step = 1 and hold dev_in.
  - Sample dev_continue, dev_out_tag and dev_out_data in this cycle.
  - If tag = 1, push dev_out_data into the FIFO. If tag = 0, push nothing.
  - step_count += 1, saturating at 16'hFFFF.
  - Next state: HALTED if dev_continue = 0, else IDLE.
- HALTED: done = 1, in_ready = 0, dev_step = 0. The FIFO keeps draining normally. The only exit is rst.
- in_ready is 0 in STEP and HALTED.
- Space for a step's output is reserved at acceptance, so a push never meets a full FIFO. A Nothing step does not consume the reserved slot.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Data in the FIFO is never dropped or reordered.

## Timing
- Reset values: in_ready 0 during rst, then 1 in the first cycle after release (FIFO empty). dev_step 0, dev_in 0, out_valid 0, out_data 0, done 0, step_count 0, state IDLE, FIFO empty.
- Throughput: one step per 2 cycles maximum (accept cycle T, step cycle T+1, next accept at T+2).
- Latency: word accepted at T produces out_valid = 1 at T+2 if the FIFO was empty and the tag was Just.
- done asserts at T+2 for a terminating step fired at T+1.
- out_data is the registered FIFO head. It is stable while out_valid & !out_ready.
- Reset mid-operation (any state, including STEP) clears everything immediately. The device shares rst, so no partial step survives.

## Structure
- Package rw_seq_pkg holds:
  - the state enum seq_state_t {IDLE, STEP, HALTED};
  - default DATA_W and FIFO_DEPTH localparams;
  - the step_count width and saturation constant.
- Sub-module rw_seq_fifo: synchronous FIFO with push/pop, full/empty, count, asynchronous active-high reset. The FSM, dev_in latch and counter live in rw_step_sequencer.

## Test plan
- Reset then single word 8'h5A, device Just 8'hA5, continue = 1 → dev_step pulses once at T+1 with dev_in = 8'h5A; out_valid at T+2 with out_data = 8'hA5; step_count = 1; done = 0.
- Device returns Nothing, continue = 1, for 3 words → 3 dev_step pulses; out_valid stays 0; step_count = 3.
- out_ready held 0, 4 Just steps (data 1,2,3,4) → in_ready drops after the 4th acceptance. Then raise out_ready → pops 1,2,3,4 in order, and in_ready returns the cycle after the first pop.
- Device drops continue on the 2nd step with Just 8'h33 → 8'h33 is still pushed; done = 1 from the following cycle; in_ready stays 0 with in_valid held high; FIFO drains; no further dev_step.
- Assert rst during STEP with 2 FIFO entries → all outputs return to reset values; FIFO empty; step_count = 0; next word is processed normally.
- Force step_count to 16'hFFFE, then fire 3 steps → saturates at 16'hFFFF.
